ysyx_25040101_alu_result_stage: RTL and testbench

Registered, parametrised successor to the combinational ALU result handler. It sits between EXU arithmetic and LSU/WBU. It resolves SLT/SLTU, all six RISC-V branch conditions and CSRRW/CSRRS/CSRRC write data from a single subtract result. Each resolved result is queued in a DEPTH-entry FIFO, so the ALU side is decoupled from downstream stalls by a valid/ready handshake.

---
 rtl/ysyx_25040101_alu_result_stage.sv | 230 +++++++++++++++++++++++
 tb/tb_ysyx_25040101_alu_result_stage.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040101_alu_result_stage.sv
// ysyx_25040101_alu_result_stage
//
// Registered ALU result stage between EXU arithmetic and LSU/WBU. It takes one
// subtract result and works out:
//   - the SLT/SLTU register value,
//   - the branch-taken flag for all six RISC-V branch conditions,
//   - the CSRRW/CSRRS/CSRRC write data and write enable.
// Each resolved result goes into a DEPTH-entry FIFO. A valid/ready handshake
// on each side decouples the ALU from downstream stalls.
//
// Parameters:
//   XLEN  - datapath width (32 or 64)
//   DEPTH - FIFO entries (power of two, >= 2)
//
// Ports:
//   clk, rst_n          - clock and synchronous active-low reset
//   flush_i             - synchronous queue clear (pipeline redirect)
//   in_valid_i/ready_o  - upstream handshake
//   borrow_i            - subtract borrow (unsigned less)
//   sub_overflow_i      - subtract signed overflow
//   tmp_data_i          - ALU result / CSR operand
//   op_i                - 0 PASS, 1 SLT, 2 SLTU, 3..8 branches, 9 CSR, 10..15 PASS
//   csr_op_i            - 0 RW, 1 RS, 2 RC, 3 none
//   csr_rdata_i         - current CSR value
//   rd_addr_i           - destination register
//   out_valid_o/ready_i - downstream handshake
//   out_*_o             - head entry fields
//   taken_cnt_o         - saturating count of taken branches popped downstream
module ysyx_25040101_alu_result_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic            borrow_i,
    input  logic            sub_overflow_i,
    input  logic [XLEN-1:0] tmp_data_i,
    input  logic [3:0]      op_i,
    input  logic [1:0]      csr_op_i,
    input  logic [XLEN-1:0] csr_rdata_i,
    input  logic [4:0]      rd_addr_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_rd_data_o,
    output logic [4:0]      out_rd_addr_o,
    output logic            out_rd_we_o,
    output logic [XLEN-1:0] out_csr_wdata_o,
    output logic            out_csr_we_o,
    output logic            out_taken_o,
    output logic [31:0]     taken_cnt_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    localparam logic [3:0] OpSlt  = 4'd1;
    localparam logic [3:0] OpSltu = 4'd2;
    localparam logic [3:0] OpBeq  = 4'd3;
    localparam logic [3:0] OpBne  = 4'd4;
    localparam logic [3:0] OpBlt  = 4'd5;
    localparam logic [3:0] OpBge  = 4'd6;
    localparam logic [3:0] OpBltu = 4'd7;
    localparam logic [3:0] OpBgeu = 4'd8;
    localparam logic [3:0] OpCsr  = 4'd9;

    localparam logic [1:0] CsrRw = 2'd0;
    localparam logic [1:0] CsrRs = 2'd1;
    localparam logic [1:0] CsrRc = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0] rd_data;
        logic [4:0]      rd_addr;
        logic            rd_we;
        logic [XLEN-1:0] csr_wdata;
        logic            csr_we;
        logic            taken;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           in_entry;
    entry_t           head;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [31:0]      taken_cnt_q, taken_cnt_d;

    logic zero, ult, slt;
    logic push, pop;

    // Flags derived from the single subtract result.
    assign zero = (tmp_data_i == '0);
    assign ult  = borrow_i;
    assign slt  = tmp_data_i[XLEN-1] ^ sub_overflow_i;

    // Resolve the incoming result into a FIFO entry.
    always_comb begin
        in_entry           = '0;
        in_entry.rd_data   = tmp_data_i;
        in_entry.rd_addr   = rd_addr_i;
        in_entry.rd_we     = 1'b1;
        in_entry.csr_wdata = '0;
        in_entry.csr_we    = 1'b0;
        in_entry.taken     = 1'b0;
        case (op_i)
            OpSlt:  in_entry.rd_data = {{(XLEN-1){1'b0}}, slt};
            OpSltu: in_entry.rd_data = {{(XLEN-1){1'b0}}, ult};
            OpBeq: begin
                in_entry.taken = zero;
                in_entry.rd_we = 1'b0;
            end
            OpBne: begin
                in_entry.taken = ~zero;
                in_entry.rd_we = 1'b0;
            end
            OpBlt: begin
                in_entry.taken = slt;
                in_entry.rd_we = 1'b0;
            end
            OpBge: begin
                in_entry.taken = ~slt;
                in_entry.rd_we = 1'b0;
            end
            OpBltu: begin
                in_entry.taken = ult;
                in_entry.rd_we = 1'b0;
            end
            OpBgeu: begin
                in_entry.taken = ~ult;
                in_entry.rd_we = 1'b0;
            end
            OpCsr: begin
                in_entry.rd_data = csr_rdata_i;
                case (csr_op_i)
                    CsrRw: begin
                        in_entry.csr_wdata = tmp_data_i;
                        in_entry.csr_we    = 1'b1;
                    end
                    CsrRs: begin
                        in_entry.csr_wdata = csr_rdata_i | tmp_data_i;
                        in_entry.csr_we    = ~zero;
                    end
                    CsrRc: begin
                        in_entry.csr_wdata = csr_rdata_i & ~tmp_data_i;
                        in_entry.csr_we    = ~zero;
                    end
                    default: begin
                        in_entry.csr_wdata = '0;
                        in_entry.csr_we    = 1'b0;
                    end
                endcase
            end
            default: ;  // PASS, including unused codes 10..15
        endcase
    end

    // Handshake signals depend only on registered count.
    assign in_ready_o  = (count_q != CntFull);
    assign out_valid_o = (count_q != '0);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;
    assign head        = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        taken_cnt_d = taken_cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
                if (head.taken && (taken_cnt_q != '1)) begin
                    taken_cnt_d = taken_cnt_q + 32'd1;
                end
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CntOne;
                2'b01:   count_d = count_q - CntOne;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            taken_cnt_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            taken_cnt_q <= taken_cnt_d;
            if (flush_i) begin
                // Storage is zeroed so an empty queue presents all-zero data.
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    mem_q[i] <= '0;
                end
            end else if (push) begin
                mem_q[wr_ptr_q] <= in_entry;
            end
        end
    end

    assign out_rd_data_o   = head.rd_data;
    assign out_rd_addr_o   = head.rd_addr;
    assign out_rd_we_o     = head.rd_we;
    assign out_csr_wdata_o = head.csr_wdata;
    assign out_csr_we_o    = head.csr_we;
    assign out_taken_o     = head.taken;
    assign taken_cnt_o     = taken_cnt_q;

endmodule

// File: tb/tb_ysyx_25040101_alu_result_stage.sv
module tb_ysyx_25040101_alu_result_stage;

    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        borrow_i;
    logic        sub_overflow_i;
    logic [31:0] tmp_data_i;
    logic [3:0]  op_i;
    logic [1:0]  csr_op_i;
    logic [31:0] csr_rdata_i;
    logic [4:0]  rd_addr_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_rd_data_o;
    logic [4:0]  out_rd_addr_o;
    logic        out_rd_we_o;
    logic [31:0] out_csr_wdata_o;
    logic        out_csr_we_o;
    logic        out_taken_o;
    logic [31:0] taken_cnt_o;

    int checks = 0;
    int errors = 0;

    ysyx_25040101_alu_result_stage #(
        .XLEN (32),
        .DEPTH(2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .borrow_i       (borrow_i),
        .sub_overflow_i (sub_overflow_i),
        .tmp_data_i     (tmp_data_i),
        .op_i           (op_i),
        .csr_op_i       (csr_op_i),
        .csr_rdata_i    (csr_rdata_i),
        .rd_addr_i      (rd_addr_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_rd_data_o  (out_rd_data_o),
        .out_rd_addr_o  (out_rd_addr_o),
        .out_rd_we_o    (out_rd_we_o),
        .out_csr_wdata_o(out_csr_wdata_o),
        .out_csr_we_o   (out_csr_we_o),
        .out_taken_o    (out_taken_o),
        .taken_cnt_o    (taken_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic [3:0] op, input logic [31:0] tmp, input logic borrow,
                          input logic ovf, input logic [1:0] cop, input logic [31:0] crd,
                          input logic [4:0] rd);
        op_i           = op;
        tmp_data_i     = tmp;
        borrow_i       = borrow;
        sub_overflow_i = ovf;
        csr_op_i       = cop;
        csr_rdata_i    = crd;
        rd_addr_i      = rd;
    endtask

    // Called just after a falling edge; returns just after the accepting rising edge.
    task automatic push_one(input logic [3:0] op, input logic [31:0] tmp, input logic borrow,
                            input logic ovf, input logic [1:0] cop, input logic [31:0] crd,
                            input logic [4:0] rd);
        int waited = 0;
        set_in(op, tmp, borrow, ovf, cop, crd, rd);
        in_valid_i = 1'b1;
        while (!in_ready_o && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!in_ready_o) begin
            errors++;
            $display("FAIL push_timeout: in_ready_o=%0b required 1", in_ready_o);
        end
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        flush_i     = 1'b0;
        out_ready_i = 1'b0;
        set_in(4'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 2'd3, 32'h0, 5'd9);
        in_valid_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready_o);
        end
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid_o);
        end
        checks++;
        if ({out_rd_data_o, out_rd_addr_o, out_rd_we_o, out_csr_wdata_o, out_csr_we_o,
             out_taken_o} !== '0) begin
            errors++; $display("FAIL reset_out_data: rd_data=%h csr_wdata=%h not all zero",
                               out_rd_data_o, out_csr_wdata_o);
        end
        checks++;
        if (taken_cnt_o !== 32'd0) begin
            errors++; $display("FAIL reset_taken_cnt: got %0d want 0", taken_cnt_o);
        end
        in_valid_i = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_nothing_pushed: out_valid=%0b want 0", out_valid_o);
        end
    endtask

    task automatic test_branches();
        out_ready_i = 1'b1;
        // BLT: 0x8000_0000 with no overflow means negative -> taken
        push_one(4'd5, 32'h8000_0000, 1'b0, 1'b0, 2'd3, 32'h0, 5'd1);
        @(negedge clk);
        checks++;
        if ({out_valid_o, out_taken_o, out_rd_we_o} !== 3'b110) begin
            errors++; $display("FAIL blt: valid/taken/we=%b want 110",
                               {out_valid_o, out_taken_o, out_rd_we_o});
        end
        checks++;
        if (out_rd_data_o !== 32'h8000_0000) begin
            errors++; $display("FAIL blt_rd_data: got %h want 80000000", out_rd_data_o);
        end
        push_one(4'd6, 32'h8000_0000, 1'b0, 1'b0, 2'd3, 32'h0, 5'd1);
        @(negedge clk);
        checks++;
        if ({out_valid_o, out_taken_o, out_rd_we_o} !== 3'b100) begin
            errors++; $display("FAIL bge: valid/taken/we=%b want 100",
                               {out_valid_o, out_taken_o, out_rd_we_o});
        end
        push_one(4'd7, 32'h0000_0005, 1'b1, 1'b0, 2'd3, 32'h0, 5'd1);
        @(negedge clk);
        checks++;
        if ({out_valid_o, out_taken_o} !== 2'b11) begin
            errors++; $display("FAIL bltu: valid/taken=%b want 11", {out_valid_o, out_taken_o});
        end
        push_one(4'd3, 32'h0, 1'b0, 1'b0, 2'd3, 32'h0, 5'd1);
        @(negedge clk);
        checks++;
        if ({out_valid_o, out_taken_o} !== 2'b11) begin
            errors++; $display("FAIL beq: valid/taken=%b want 11", {out_valid_o, out_taken_o});
        end
        @(negedge clk);
        checks++;
        if (taken_cnt_o !== 32'd3) begin
            errors++; $display("FAIL taken_cnt_branches: got %0d want 3", taken_cnt_o);
        end
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++; $display("FAIL branches_drained: out_valid=%0b want 0", out_valid_o);
        end
    endtask

    task automatic test_slt();
        out_ready_i = 1'b1;
        push_one(4'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 2'd3, 32'h0, 5'd4);
        @(negedge clk);
        checks++;
        if ({out_rd_data_o, out_rd_we_o, out_rd_addr_o} !== {32'd1, 1'b1, 5'd4}) begin
            errors++; $display("FAIL slt: data=%h we=%0b rd=%0d want 1/1/4",
                               out_rd_data_o, out_rd_we_o, out_rd_addr_o);
        end
        push_one(4'd2, 32'h0000_1234, 1'b0, 1'b0, 2'd3, 32'h0, 5'd6);
        @(negedge clk);
        checks++;
        if ({out_rd_data_o, out_rd_we_o} !== {32'd0, 1'b1}) begin
            errors++; $display("FAIL sltu: data=%h we=%0b want 0/1", out_rd_data_o, out_rd_we_o);
        end
        // Unused op code behaves as PASS
        push_one(4'd12, 32'h0000_ABCD, 1'b1, 1'b1, 2'd0, 32'h1, 5'd0);
        @(negedge clk);
        checks++;
        if ({out_rd_data_o, out_rd_we_o, out_taken_o, out_csr_we_o, out_csr_wdata_o} !==
            {32'h0000_ABCD, 1'b1, 1'b0, 1'b0, 32'h0}) begin
            errors++; $display("FAIL op12_pass: data=%h we=%0b taken=%0b csr_we=%0b want abcd/1/0/0",
                               out_rd_data_o, out_rd_we_o, out_taken_o, out_csr_we_o);
        end
    endtask

    task automatic test_csr();
        logic [1:0]  cops   [5] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd3};
        logic [31:0] tmps   [5] = '{32'h0F, 32'h0F, 32'h0F, 32'h0, 32'h0F};
        logic [31:0] wdatas [5] = '{32'h0F, 32'hFF, 32'hF0, 32'hF0, 32'h0};
        logic        wes    [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        out_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_one(4'd9, tmps[i], 1'b0, 1'b0, cops[i], 32'hF0, 5'd5);
            @(negedge clk);
            checks++;
            if ({out_csr_wdata_o, out_csr_we_o} !== {wdatas[i], wes[i]}) begin
                errors++; $display("FAIL csr_%0d: wdata=%h we=%0b want %h/%0b",
                                   i, out_csr_wdata_o, out_csr_we_o, wdatas[i], wes[i]);
            end
            checks++;
            if ({out_rd_data_o, out_rd_we_o, out_taken_o} !== {32'hF0, 1'b1, 1'b0}) begin
                errors++; $display("FAIL csr_rd_%0d: data=%h we=%0b want f0/1",
                                   i, out_rd_data_o, out_rd_we_o);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        out_ready_i = 1'b0;
        set_in(4'd0, 32'h11, 1'b0, 1'b0, 2'd3, 32'h0, 5'd1);
        in_valid_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready_o, out_valid_o} !== 2'b11) begin
            errors++; $display("FAIL bp_one: ready/valid=%b want 11", {in_ready_o, out_valid_o});
        end
        set_in(4'd0, 32'h22, 1'b0, 1'b0, 2'd3, 32'h0, 5'd2);
        @(negedge clk);
        checks++;
        if ({in_ready_o, out_valid_o} !== 2'b01) begin
            errors++; $display("FAIL bp_full: ready/valid=%b want 01", {in_ready_o, out_valid_o});
        end
        set_in(4'd0, 32'h33, 1'b0, 1'b0, 2'd3, 32'h0, 5'd3);
        @(negedge clk);
        checks++;
        if ({in_ready_o, out_rd_data_o, out_rd_addr_o} !== {1'b0, 32'h11, 5'd1}) begin
            errors++; $display("FAIL bp_hold: ready=%0b head=%h rd=%0d want 0/11/1",
                               in_ready_o, out_rd_data_o, out_rd_addr_o);
        end
        out_ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready_o, out_valid_o, out_rd_data_o} !== {2'b11, 32'h22}) begin
            errors++; $display("FAIL bp_pop1: ready/valid=%b head=%h want 11/22",
                               {in_ready_o, out_valid_o}, out_rd_data_o);
        end
        // Push C and pop B in the same edge; count stays at 1.
        @(negedge clk);
        checks++;
        if ({in_ready_o, out_valid_o, out_rd_data_o, out_rd_addr_o} !==
            {2'b11, 32'h33, 5'd3}) begin
            errors++; $display("FAIL bp_pushpop: ready/valid=%b head=%h want 11/33",
                               {in_ready_o, out_valid_o}, out_rd_data_o);
        end
        in_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready_o, out_valid_o} !== 2'b10) begin
            errors++; $display("FAIL bp_drain: ready/valid=%b want 10", {in_ready_o, out_valid_o});
        end
        checks++;
        if (taken_cnt_o !== 32'd3) begin
            errors++; $display("FAIL bp_taken_cnt: got %0d want 3", taken_cnt_o);
        end
    endtask

    task automatic test_flush();
        out_ready_i = 1'b0;
        push_one(4'd3, 32'h0, 1'b0, 1'b0, 2'd3, 32'h0, 5'd7);
        @(negedge clk);
        push_one(4'd0, 32'h44, 1'b0, 1'b0, 2'd3, 32'h0, 5'd8);
        @(negedge clk);
        checks++;
        if ({in_ready_o, out_valid_o, out_taken_o} !== 3'b011) begin
            errors++; $display("FAIL flush_setup: ready/valid/taken=%b want 011",
                               {in_ready_o, out_valid_o, out_taken_o});
        end
        flush_i     = 1'b1;
        out_ready_i = 1'b1;
        set_in(4'd3, 32'h0, 1'b0, 1'b0, 2'd3, 32'h0, 5'd9);
        in_valid_i = 1'b1;
        @(negedge clk);
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        checks++;
        if ({in_ready_o, out_valid_o, out_rd_data_o, out_taken_o} !== {2'b10, 32'h0, 1'b0}) begin
            errors++; $display("FAIL flush_clear: ready/valid=%b data=%h want 10/0",
                               {in_ready_o, out_valid_o}, out_rd_data_o);
        end
        checks++;
        if (taken_cnt_o !== 32'd3) begin
            errors++; $display("FAIL flush_taken_cnt: got %0d want 3", taken_cnt_o);
        end
        push_one(4'd0, 32'h55, 1'b0, 1'b0, 2'd3, 32'h0, 5'd10);
        @(negedge clk);
        checks++;
        if ({out_valid_o, out_rd_data_o, out_rd_addr_o} !== {1'b1, 32'h55, 5'd10}) begin
            errors++; $display("FAIL flush_after: valid=%0b head=%h want 1/55",
                               out_valid_o, out_rd_data_o);
        end
        @(negedge clk);
    endtask

    initial begin
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        rst_n       = 1'b0;
        set_in(4'd0, 32'h0, 1'b0, 1'b0, 2'd3, 32'h0, 5'd0);
        @(negedge clk);
        test_reset();
        test_branches();
        test_slt();
        test_csr();
        test_back_to_back();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
